fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end for the RISC-V pipeline. It owns the program counter, runs the read handshake with the instruction memory or cache, and presents `pc_out`, `pc_4_out`, `instruction_out` and `busywait_imem` to the IF pipeline register. It also applies branch/jump redirects, including redirects that arrive while a memory read is still outstanding.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1: pipeline clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `branch_jump_signal`  in  1: redirect request from EX, sampled at the rising edge.
- `branch_target`  in  32: redirect PC; bits [1:0] ignored and treated as 0.
- `hold`  in  1: downstream hazard stall.
- `busywait`  in  1: data-memory stall.
- `imem_read`  out  1: instruction read request.
- `imem_address`  out  32: word-aligned read address; stable while `imem_read`=1.
- `imem_readdata`  in  32: read data; valid when `imem_busywait`=0.
- `imem_busywait`  in  1: memory not done.
- `pc_out`  out  32: PC of the presented instruction.
- `pc_4_out`  out  32: `pc_out`+4, modulo 2^32.
- `instruction_out`  out  32: presented instruction; 0 when not valid.
- `busywait_imem`  out  1: 1 means `instruction_out` is not valid this cycle.

## Operation
- Memory read completes at a rising edge where `imem_read`=1 and `imem_busywait`=0.
- Accept condition: `accept` = !`busywait` & !`hold`.
- Internal state:
  - `pc` register: 32 bits.
  - `req_addr` register: 32 bits, the address of the outstanding read.
  - `buf` register: 32 bits.
  - FSM with states START, FETCH, BUFFERED, DISCARD.
- START (entered on reset):
  - `imem_read`=0, `busywait_imem`=1.
  - Moves to FETCH next cycle.
- FETCH:
  - `imem_read`=1, `imem_address`=`pc`, `req_addr` tracks `pc`.
  - When `imem_busywait`=0: `instruction_out`=`imem_readdata`, `busywait_imem`=0. Otherwise `instruction_out`=0, `busywait_imem`=1.
  - Redirect at the edge: `pc`<=target. Next state is DISCARD if `imem_busywait`=1, else FETCH.
  - Completion with `accept`: `pc`<=`pc`+4, stay in FETCH.
  - Completion without `accept`: see Configuration.
- BUFFERED:
  - `imem_read`=0, `instruction_out`=`buf`, `busywait_imem`=0.
  - Redirect: `pc`<=target, go to FETCH.
  - `accept`: `pc`<=`pc`+4, go to FETCH.
  - Otherwise hold.
- DISCARD:
  - `imem_read`=1, `imem_address`=`req_addr` (the old address), `busywait_imem`=1, `instruction_out`=0.
  - Further redirects overwrite `pc` with the newest target.
  - On completion the data is dropped and the FSM goes to FETCH at `pc`.
- Priority at any edge: `reset` > redirect > completion/`accept` > hold.
- Redirect and the IF-register flush occur in the same cycle, so the instruction presented on that cycle is never advanced.
- `pc_4_out` wraps: 32'hFFFF_FFFC gives 32'h0000_0000.

## Timing
- Values while `reset`=1:
  - `pc_out`=`RESET_PC`, `pc_4_out`=`RESET_PC`+4.
  - `instruction_out`=0, `busywait_imem`=1.
  - `imem_read`=0, `imem_address`=`RESET_PC`, `buf`=0.
- First request: the cycle after reset release, i.e. one START cycle.
- Combinational paths:
  - `imem_readdata` to `instruction_out`.
  - `imem_busywait` to `busywait_imem`.
  - State and `pc` to `imem_address`.
- No combinational path from `hold`/`busywait` to `imem_address`.
- Throughput: one instruction per cycle while memory responds with `imem_busywait`=0.
- An N-cycle memory wait gives N cycles of `busywait_imem`=1.
- Redirect latency:
  - Idle memory: the target is requested the next cycle.
  - Busy memory: the target is requested the cycle after the discarded read completes.
- Reset asserted mid-read: the request is abandoned immediately and the FSM re-enters START.

## Configuration
- `FETCH_SKID_BUF_EN` defined:
  - Completion without `accept` captures `imem_readdata` into `buf` and enters BUFFERED.
  - `imem_read` drops during the stall.
- `FETCH_SKID_BUF_EN` undefined:
  - No `buf` and no BUFFERED state.
  - Completion without `accept` stays in FETCH with the same `pc`, keeping `imem_read`=1 and re-reading the same address until accepted.
- Externally visible instruction stream is identical in both builds.

## Test plan
- Reset, `RESET_PC`=0: outputs at the reset values above. One cycle after release, `imem_read`=1 with `imem_address`=0x0.
- Zero-wait memory, no stalls: `pc_out` runs 0x0, 0x4, 0x8, 0xC on consecutive cycles. `instruction_out` matches memory each cycle and `busywait_imem`=0 throughout.
- `imem_busywait` high for 3 cycles at 0x10: `busywait_imem`=1 and `imem_address`=0x10 for all 3 cycles. The instruction appears on the 4th cycle.
- `hold`=1 for 2 cycles over a completed fetch at 0x14:
  - With the macro: `imem_read`=0 and the instruction stays stable.
  - Both builds: after release, the next request is 0x18.
- Redirect to 0x100 while the read at 0x20 has `imem_busywait`=1: `imem_address` stays 0x20 until completion. That data never gets `busywait_imem`=0. The next request is 0x100.
- Accept at `pc`=0xFFFF_FFFC: `pc_4_out`=0x0 and the next `imem_address`=0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Owns the PC, drives the instruction-memory read handshake and presents
// pc / pc+4 / instruction / valid to the IF pipeline register. Redirects that
// land while a read is outstanding are parked in DISCARD until the old read
// completes, because the old address must stay stable on the memory port.
// Optional feature macro: FETCH_SKID_BUF_EN (adds a one-entry skid buffer so
// a completed-but-stalled fetch is held locally instead of re-read).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_jump_signal,
  input  logic [31:0] branch_target,
  input  logic        hold,
  input  logic        busywait,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_readdata,
  input  logic        imem_busywait,
  output logic [31:0] pc_out,
  output logic [31:0] pc_4_out,
  output logic [31:0] instruction_out,
  output logic        busywait_imem
);

`ifdef FETCH_SKID_BUF_EN
  typedef enum logic [1:0] {
    START    = 2'd0,
    FETCH    = 2'd1,
    DISCARD  = 2'd2,
    BUFFERED = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    START    = 2'd0,
    FETCH    = 2'd1,
    DISCARD  = 2'd2
  } state_t;
`endif

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] req_addr_reg, req_addr_next;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        accept;

  // Masking (rather than slicing) keeps every target bit in use while
  // forcing word alignment.
  assign target   = branch_target & ~32'd3;
  assign pc_plus4 = pc_reg + 32'd4;
  assign accept   = !busywait && !hold;

  assign pc_out   = pc_reg;
  assign pc_4_out = pc_plus4;

`ifdef FETCH_SKID_BUF_EN
  logic [31:0] buf_reg, buf_next;

  // Skid buffer holds the word that completed while the pipeline stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) buf_reg <= 32'd0;
    else       buf_reg <= buf_next;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= START;
    else       state_reg <= state_next;
  end

  // PC and outstanding-request address registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg       <= RESET_PC;
      req_addr_reg <= RESET_PC;
    end else begin
      pc_reg       <= pc_next;
      req_addr_reg <= req_addr_next;
    end
  end

  // Next-state, next-PC and output decode; redirect outranks completion/accept.
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    req_addr_next   = req_addr_reg;
`ifdef FETCH_SKID_BUF_EN
    buf_next        = buf_reg;
`endif
    imem_read       = 1'b0;
    imem_address    = pc_reg;
    instruction_out = 32'd0;
    busywait_imem   = 1'b1;

    case (state_reg)
      START: begin
        state_next = FETCH;
        if (branch_jump_signal) pc_next = target;
      end

      FETCH: begin
        imem_read     = 1'b1;
        req_addr_next = pc_reg;
        if (!imem_busywait) begin
          instruction_out = imem_readdata;
          busywait_imem   = 1'b0;
        end
        if (branch_jump_signal) begin
          // A still-busy read cannot be cancelled; park in DISCARD until it drains.
          pc_next    = target;
          state_next = imem_busywait ? DISCARD : FETCH;
        end else if (!imem_busywait) begin
          if (accept) begin
            pc_next = pc_plus4;
          end else begin
`ifdef FETCH_SKID_BUF_EN
            buf_next   = imem_readdata;
            state_next = BUFFERED;
`else
            // Stay put and re-read the same word until the pipeline accepts it.
            state_next = FETCH;
`endif
          end
        end
      end

      DISCARD: begin
        imem_read    = 1'b1;
        imem_address = req_addr_reg;
        if (branch_jump_signal) pc_next = target;
        if (!imem_busywait)     state_next = FETCH;
      end

`ifdef FETCH_SKID_BUF_EN
      BUFFERED: begin
        instruction_out = buf_reg;
        busywait_imem   = 1'b0;
        if (branch_jump_signal) begin
          pc_next    = target;
          state_next = FETCH;
        end else if (accept) begin
          pc_next    = pc_plus4;
          state_next = FETCH;
        end
      end
`endif

      default: begin
        state_next = START;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan steps followed by a randomized phase,
// every cycle checked against an instruction-stream reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch_jump_signal = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        hold = 1'b0;
  logic        busywait = 1'b0;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_readdata;
  logic        imem_busywait = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] pc_4_out;
  logic [31:0] instruction_out;
  logic        busywait_imem;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk                (clk),
    .reset              (reset),
    .branch_jump_signal (branch_jump_signal),
    .branch_target      (branch_target),
    .hold               (hold),
    .busywait           (busywait),
    .imem_read          (imem_read),
    .imem_address       (imem_address),
    .imem_readdata      (imem_readdata),
    .imem_busywait      (imem_busywait),
    .pc_out             (pc_out),
    .pc_4_out           (pc_4_out),
    .instruction_out    (instruction_out),
    .busywait_imem      (busywait_imem)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: distinct word for every address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_readdata = memfn(imem_address);

  // Reference model: where the instruction stream is (m_pc), whether the
  // first post-reset cycle is pending, whether a redirected read is still
  // draining (m_discard, at m_old), and whether a stalled word is held.
  logic [31:0] m_pc, m_old;
  bit          m_start, m_discard, m_buf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0000_0000;
    m_old     = 32'h0000_0000;
    m_start   = 1'b1;
    m_discard = 1'b0;
    m_buf     = 1'b0;
  endtask

  // One cycle: drive inputs, check all outputs against the model, advance the model.
  task automatic step(input bit rst, input bit bj, input logic [31:0] tgt,
                      input bit hd, input bit bw, input bit ibw);
    bit          e_valid, e_read, acc, cmp;
    logic [31:0] e_addr, tg;
    @(negedge clk);
    reset              = rst;
    branch_jump_signal = bj;
    branch_target      = tgt;
    hold               = hd;
    busywait           = bw;
    imem_busywait      = ibw;
    if (rst) model_reset();
    #1;
    cycle++;
    e_valid = !m_start && !m_discard && (m_buf || !ibw);
    e_read  = !m_start && !m_buf;
    e_addr  = m_discard ? m_old : m_pc;
    chk("pc_out",          pc_out,          m_pc);
    chk("pc_4_out",        pc_4_out,        m_pc + 32'd4);
    chk("busywait_imem",   {31'd0, busywait_imem}, {31'd0, !e_valid});
    chk("instruction_out", instruction_out, e_valid ? memfn(m_pc) : 32'd0);
    chk("imem_read",       {31'd0, imem_read}, {31'd0, e_read});
    chk("imem_address",    imem_address,    e_addr);
    $display("cyc %0d rst=%0b bj=%0b tgt=%08h hold=%0b bw=%0b ibw=%0b | rd=%0b addr=%08h pc=%08h ins=%08h bwi=%0b",
             cycle, rst, bj, tgt, hd, bw, ibw, imem_read, imem_address, pc_out, instruction_out, busywait_imem);
    if (!rst) begin
      tg  = tgt & ~32'd3;
      acc = !hd && !bw;
      cmp = e_read && !ibw;
      if (m_start) begin
        m_start = 1'b0;
        if (bj) m_pc = tg;
      end else if (bj) begin
        if (m_discard)  m_discard = !cmp;
        else if (m_buf) m_buf = 1'b0;
        else if (!cmp) begin
          m_old     = m_pc;
          m_discard = 1'b1;
        end
        m_pc = tg;
      end else if (m_discard) begin
        if (cmp) m_discard = 1'b0;
      end else if (m_buf) begin
        if (acc) begin
          m_buf = 1'b0;
          m_pc  = m_pc + 32'd4;
        end
      end else if (cmp) begin
        if (acc) m_pc = m_pc + 32'd4;
`ifdef FETCH_SKID_BUF_EN
        else     m_buf = 1'b1;
`endif
      end
    end
  endtask

  initial begin
    model_reset();

    // Reset values.
    step(1, 0, 0, 0, 0, 0);
    chk("rst_pc_out",   pc_out,          32'h0);
    chk("rst_pc_4_out", pc_4_out,        32'h4);
    chk("rst_instr",    instruction_out, 32'h0);
    chk("rst_bwi",      {31'd0, busywait_imem}, 32'd1);
    chk("rst_read",     {31'd0, imem_read},     32'd0);
    chk("rst_addr",     imem_address,    32'h0);
    step(1, 0, 0, 0, 0, 0);

    // START cycle, then zero-wait streaming 0x0..0xC.
    step(0, 0, 0, 0, 0, 0);
    chk("start_no_read", {31'd0, imem_read}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (i == 0) chk("first_req_addr", imem_address, 32'h0);
      chk("seq_pc",    pc_out, 32'(i * 4));
      chk("seq_valid", {31'd0, busywait_imem}, 32'd0);
      chk("seq_instr", instruction_out, memfn(32'(i * 4)));
    end

    // Three-cycle memory wait at 0x10.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("wait_addr", imem_address, 32'h10);
      chk("wait_busy", {31'd0, busywait_imem}, 32'd1);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("wait_done_pc",    pc_out, 32'h10);
    chk("wait_done_instr", instruction_out, memfn(32'h10));

    // Two-cycle hold over a completed fetch at 0x14.
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
`ifdef FETCH_SKID_BUF_EN
    chk("hold_no_read", {31'd0, imem_read}, 32'd0);
`endif
    chk("hold_instr", instruction_out, memfn(32'h14));
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("after_hold_addr", imem_address, 32'h18);
    step(0, 0, 0, 0, 0, 0);

    // Redirect to 0x100 while the read at 0x20 is busy.
    step(0, 1, 32'h100, 0, 0, 1);
    chk("redir_old_addr", imem_address, 32'h20);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("discard_addr", imem_address, 32'h20);
      chk("discard_busy", {31'd0, busywait_imem}, 32'd1);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("discard_done_addr", imem_address, 32'h20);
    chk("discard_done_busy", {31'd0, busywait_imem}, 32'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("redir_target_addr", imem_address, 32'h100);

    // Wrap at 0xFFFF_FFFC (low target bits ignored).
    step(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("wrap_pc",   pc_out,   32'hFFFF_FFFC);
    chk("wrap_pc_4", pc_4_out, 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("wrap_next_addr", imem_address, 32'h0);

    // Reset in the middle of a busy read.
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("rst_mid_read", {31'd0, imem_read}, 32'd0);
    chk("rst_mid_bwi",  {31'd0, busywait_imem}, 32'd1);
    step(0, 0, 0, 0, 0, 0);

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 7) == 0,
           $urandom,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
